// File: rtl/wb_retire_buf_if.sv
// Bus bundle between MEM, the write-back retire buffer, the register file and ID forwarding.
// Debug trace signals exist only when WB_DEBUG_TRACE_EN is defined.
interface wb_retire_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned ENT_W = PC_W + 5 + DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ENT_W-1:0]  in_data;
  logic              in_valid;
  logic              in_allow;
  logic              rf_stall;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [4:0]        fwd_raddr1;
  logic [4:0]        fwd_raddr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  occupancy;
`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_we;
  logic [4:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;
`endif

  modport slave (
    input  in_data, in_valid, rf_stall, fwd_raddr1, fwd_raddr2,
    output in_allow, rf_we, rf_waddr, rf_wdata,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, occupancy
`ifdef WB_DEBUG_TRACE_EN
    , output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );

  modport master (
    output in_data, in_valid, rf_stall, fwd_raddr1, fwd_raddr2,
    input  in_allow, rf_we, rf_waddr, rf_wdata,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, occupancy
`ifdef WB_DEBUG_TRACE_EN
    , input debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );
endinterface

// File: rtl/wb_retire_buf.sv
// DEPTH-entry in-order retire FIFO between MEM and the register file, with two
// youngest-first forwarding ports. Debug trace outputs are gated by WB_DEBUG_TRACE_EN.
module wb_retire_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk,
  input  logic          resetn,
  wb_retire_buf_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic              gr_we;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_c, pop_c, empty_c, allow_c, rf_we_c;
  entry_t            in_ent_c, head_c;
  logic [PTR_W-1:0]  scan_idx_c;
  logic              hit1_c, hit2_c;
  logic [DATA_W-1:0] data1_c, data2_c;

  assign in_ent_c = entry_t'(bus.in_data);
  assign head_c   = mem_q[rd_ptr_q];
  assign empty_c  = (count_q == '0);
  // Full blocks MEM even on a pop cycle, keeping rf_stall off the MEM path.
  assign allow_c  = (count_q != CNT_W'(DEPTH));
  assign push_c   = bus.in_valid & allow_c;
  assign pop_c    = ~empty_c & ~bus.rf_stall;
  assign rf_we_c  = pop_c & head_c.gr_we;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is unreset; every output is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_ent_c;
  end

  // Scan oldest to youngest so the last match seen is the youngest writer.
  always_comb begin
    hit1_c     = 1'b0;
    hit2_c     = 1'b0;
    data1_c    = '0;
    data2_c    = '0;
    scan_idx_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx_c = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && mem_q[scan_idx_c].gr_we) begin
        if ((bus.fwd_raddr1 != 5'd0) && (mem_q[scan_idx_c].dest == bus.fwd_raddr1)) begin
          hit1_c  = 1'b1;
          data1_c = mem_q[scan_idx_c].result;
        end
        if ((bus.fwd_raddr2 != 5'd0) && (mem_q[scan_idx_c].dest == bus.fwd_raddr2)) begin
          hit2_c  = 1'b1;
          data2_c = mem_q[scan_idx_c].result;
        end
      end
    end
  end

  assign bus.in_allow  = allow_c;
  assign bus.rf_we     = rf_we_c;
  assign bus.rf_waddr  = empty_c ? 5'd0 : head_c.dest;
  assign bus.rf_wdata  = empty_c ? '0 : head_c.result;
  assign bus.fwd_hit1  = hit1_c;
  assign bus.fwd_hit2  = hit2_c;
  assign bus.fwd_data1 = data1_c;
  assign bus.fwd_data2 = data2_c;
  assign bus.occupancy = count_q;

`ifdef WB_DEBUG_TRACE_EN
  assign bus.debug_wb_rf_we    = {4{rf_we_c}};
  assign bus.debug_wb_pc       = pop_c ? head_c.pc : '0;
  assign bus.debug_wb_rf_wnum  = pop_c ? head_c.dest : 5'd0;
  assign bus.debug_wb_rf_wdata = pop_c ? head_c.result : '0;
`else
  // The PC field only feeds the trace port.
  logic unused_pc_c;
  assign unused_pc_c = ^head_c.pc;
`endif

endmodule
